// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the t8086 fetch front end: physical address width,
// the queue entry layout and the segment:offset address helper.
package prefetch_queue_pkg;

    localparam int unsigned PHYS_W = 20;

    // One queued instruction byte together with the offset it was fetched from.
    typedef struct packed {
        logic [15:0] ip;
        logic [7:0]  data;
    } pfq_entry_t;

    // Real-mode physical address; the carry out of bit 19 is dropped.
    function automatic logic [PHYS_W-1:0] phys_addr(input logic [15:0] cs,
                                                    input logic [15:0] ip);
        logic [PHYS_W-1:0] sum;
        sum = {cs, 4'b0000} + {4'b0000, ip};
        return sum;
    endfunction

endpackage

// File: rtl/prefetch_queue_fifo.sv
// Circular buffer of Depth {ip,byte} entries with head/tail pointers that wrap
// at Depth, an occupancy counter and a synchronous clear that beats push/pop.
module prefetch_queue_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned Depth = 6,
    localparam int unsigned LevelW = $clog2(Depth + 1),
    localparam int unsigned PtrW = $clog2(Depth)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              push_i,
    input  pfq_entry_t        wdata_i,
    input  logic              pop_i,
    output pfq_entry_t        rdata_o,
    output logic              empty_o,
    output logic [LevelW-1:0] level_o
);

    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    pfq_entry_t        mem_q [Depth];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [LevelW-1:0] level_q, level_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    // Next-state for pointers and occupancy; clear discards everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (push_i) tail_d = ptr_inc(tail_q);
            if (pop_i)  head_d = ptr_inc(head_q);
            if (push_i && !pop_i)      level_d = level_q + LevelW'(1);
            else if (!push_i && pop_i) level_d = level_q - LevelW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Storage write; entries need no reset since reads are qualified by empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
    end

    assign rdata_o = mem_q[head_q];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues ROM byte fetches from CS:IP, buffers the
// returned bytes and hands them out in program order over valid/ready.
// Optional feature macro PFQ_BYPASS_EN: a return arriving at an empty queue is
// presented on the output in the same cycle.
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 6,
    parameter logic [15:0] RESET_CS = 16'h0000,
    parameter logic [15:0] RESET_IP = 16'h0000,
    localparam int unsigned LevelW = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [15:0]       flush_cs_i,
    input  logic [15:0]       flush_ip_i,
    output logic              rom_en_o,
    output logic [PHYS_W-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic              out_valid_o,
    output logic [7:0]        out_byte_o,
    output logic [15:0]       out_ip_o,
    input  logic              out_ready_i,
    output logic [LevelW-1:0] level_o
);

    localparam logic [LevelW:0] DepthC = (LevelW + 1)'(DEPTH);

    logic        run_q;       // low until the first edge after reset release
    logic [15:0] cs_q;
    logic [15:0] ip_q;
    logic        inflight_q;  // a byte returns on rom_data_i this cycle
    logic [15:0] ret_ip_q;    // offset of the returning byte
    pfq_entry_t  hold_q;      // last presented entry, shown while empty

    logic              fifo_empty;
    logic [LevelW-1:0] fifo_level;
    pfq_entry_t        fifo_rdata;
    logic              fifo_push;
    logic              fifo_pop;
    logic [LevelW:0]   occupancy;
    logic              issue;
    logic              ret_valid;
    pfq_entry_t        ret_entry;
    logic              head_valid;
    pfq_entry_t        head_entry;

    // Issue decision on pre-pop level; a flush drops the returning byte.
    always_comb begin
        occupancy = {1'b0, fifo_level} + {{LevelW{1'b0}}, inflight_q};
        issue     = run_q && !flush_i && (occupancy < DepthC);
        ret_valid = inflight_q && !flush_i;
        ret_entry = '{ip: ret_ip_q, data: rom_data_i};
    end

`ifdef PFQ_BYPASS_EN
    // Empty queue: present the return directly; store it only if not taken.
    always_comb begin
        head_valid = !fifo_empty || ret_valid;
        head_entry = fifo_empty ? ret_entry : fifo_rdata;
        fifo_push  = ret_valid && !(fifo_empty && out_ready_i);
        fifo_pop   = !fifo_empty && out_ready_i && !flush_i;
    end
`else
    // Outputs come only from queue storage.
    always_comb begin
        head_valid = !fifo_empty;
        head_entry = fifo_rdata;
        fifo_push  = ret_valid;
        fifo_pop   = !fifo_empty && out_ready_i && !flush_i;
    end
`endif

    // Fetch pointer, in-flight tracking and held output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q      <= 1'b0;
            cs_q       <= RESET_CS;
            ip_q       <= RESET_IP;
            inflight_q <= 1'b0;
            ret_ip_q   <= '0;
            hold_q     <= '0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= issue;
            if (issue) ret_ip_q <= ip_q;
            if (flush_i) begin
                cs_q <= flush_cs_i;
                ip_q <= flush_ip_i;
            end else if (issue) begin
                ip_q <= ip_q + 16'd1;  // wraps within the segment
            end
            if (head_valid) hold_q <= head_entry;
        end
    end

    prefetch_queue_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .wdata_i (ret_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign rom_en_o    = issue;
    assign rom_addr_o  = phys_addr(cs_q, ip_q);
    assign out_valid_o = head_valid;
    assign out_byte_o  = head_valid ? head_entry.data : hold_q.data;
    assign out_ip_o    = head_valid ? head_entry.ip : hold_q.ip;
    assign level_o     = fifo_level;

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomised bench for prefetch_queue against a queue-based reference model.
module tb_prefetch_queue;

    localparam int unsigned DEPTH = 6;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
`ifdef PFQ_BYPASS_EN
    localparam int unsigned FLUSH_LAT = 2;
`else
    localparam int unsigned FLUSH_LAT = 3;
`endif

    logic          clk;
    logic          rst_ni;
    logic          flush_i;
    logic [15:0]   flush_cs_i;
    logic [15:0]   flush_ip_i;
    logic          rom_en_o;
    logic [19:0]   rom_addr_o;
    logic [7:0]    rom_data_i;
    logic          out_valid_o;
    logic [7:0]    out_byte_o;
    logic [15:0]   out_ip_o;
    logic          out_ready_i;
    logic [LW-1:0] level_o;

    prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_CS (16'h0000),
        .RESET_IP (16'h0000)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_cs_i  (flush_cs_i),
        .flush_ip_i  (flush_ip_i),
        .rom_en_o    (rom_en_o),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .out_valid_o (out_valid_o),
        .out_byte_o  (out_byte_o),
        .out_ip_o    (out_ip_o),
        .out_ready_i (out_ready_i),
        .level_o     (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned ip;
        int unsigned b;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    int unsigned m_cs, m_ip, m_pend_ip, m_pend_addr;
    bit          m_infl;
    // ROM environment state
    bit          rom_pend;
    logic [19:0] rom_req_addr;

    int unsigned n_vectors;
    int unsigned n_miscompares;

    function automatic logic [7:0] rom_byte(input int unsigned a);
        int unsigned x;
        x = (a * 37) ^ (a >> 9) ^ 32'h5A;
        return x[7:0];
    endfunction

    function automatic int unsigned phys(input int unsigned cs, input int unsigned ip);
        return (cs * 16 + ip) & 32'hFFFFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cs     = 0;
        m_ip     = 0;
        m_infl   = 0;
        rom_pend = 0;
    endtask

    // One clock: drive inputs after the edge, check at the falling edge, advance model.
    task automatic cycle(input bit fl, input logic [15:0] fcs, input logic [15:0] fip,
                         input bit rdy);
        bit          exp_en, exp_valid, ret, byp;
        ent_t        head;
        int unsigned occ;
        @(posedge clk);
        #1;
        rom_data_i  = rom_pend ? rom_byte(32'(rom_req_addr)) : 8'($urandom);
        flush_i     = fl;
        flush_cs_i  = fcs;
        flush_ip_i  = fip;
        out_ready_i = rdy;
        @(negedge clk);
        occ       = 32'(mq.size()) + (m_infl ? 32'd1 : 32'd0);
        exp_en    = !fl && (occ < DEPTH);
        ret       = m_infl && !fl;
        byp       = 1'b0;
        exp_valid = 1'b0;
        head      = '{ip: 0, b: 0};
        if (mq.size() > 0) begin
            exp_valid = 1'b1;
            head      = mq[0];
        end
`ifdef PFQ_BYPASS_EN
        else if (ret) begin
            exp_valid = 1'b1;
            byp       = 1'b1;
            head      = '{ip: m_pend_ip, b: 32'(rom_byte(m_pend_addr))};
        end
`endif
        check_eq("rom_en", 32'(rom_en_o), 32'(exp_en));
        if (exp_en) check_eq("rom_addr", 32'(rom_addr_o), phys(m_cs, m_ip));
        check_eq("out_valid", 32'(out_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("out_byte", 32'(out_byte_o), head.b);
            check_eq("out_ip", 32'(out_ip_o), head.ip);
        end
        check_eq("level", 32'(level_o), 32'(mq.size()));
        rom_pend     = rom_en_o;
        rom_req_addr = rom_addr_o;
        if (fl) begin
            mq.delete();
            m_cs   = 32'(fcs);
            m_ip   = 32'(fip);
            m_infl = 1'b0;
        end else begin
            if (exp_valid && rdy && !byp) void'(mq.pop_front());
            if (ret && !(byp && rdy))
                mq.push_back('{ip: m_pend_ip, b: 32'(rom_byte(m_pend_addr))});
            if (exp_en) begin
                m_pend_ip   = m_ip;
                m_pend_addr = phys(m_cs, m_ip);
                m_ip        = (m_ip + 1) & 32'hFFFF;
            end
            m_infl = exp_en;
        end
    endtask

    initial begin
        int unsigned lat;
        logic [19:0] wrap_exp [3];
        logic [15:0] rip;
        bit          rfl;
        bit          rrdy;
        int unsigned mode;

        n_vectors     = 0;
        n_miscompares = 0;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        flush_cs_i    = '0;
        flush_ip_i    = '0;
        out_ready_i   = 1'b0;
        rom_data_i    = '0;
        model_reset();

        // Reset state
        #2;
        check_eq("rst_rom_en", 32'(rom_en_o), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_level", 32'(level_o), 32'd0);
        check_eq("rst_out_byte", 32'(out_byte_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // Streaming with a ready consumer
        repeat (30) cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // Stalled consumer fills the queue
        repeat (12) cycle(1'b0, 16'h0, 16'h0, 1'b0);
        check_eq("full_level", 32'(level_o), DEPTH);
        check_eq("full_no_issue", 32'(rom_en_o), 32'd0);
        repeat (20) cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // Flush while nearly full with a fetch in flight
        repeat (4) cycle(1'b0, 16'h0, 16'h0, 1'b0);
        cycle(1'b1, 16'h1234, 16'h0010, 1'b0);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1);
            if (k == 1) check_eq("flush_addr", 32'(rom_addr_o), 32'h12350);
            if (out_valid_o && lat == 0) begin
                lat = k;
                check_eq("flush_first_ip", 32'(out_ip_o), 32'h0010);
            end
        end
        check_eq("flush_latency", lat, FLUSH_LAT);

        // Offset wrap within the segment
        wrap_exp[0] = 20'hFFFFE;
        wrap_exp[1] = 20'hFFFFF;
        wrap_exp[2] = 20'hF0000;
        cycle(1'b1, 16'hF000, 16'hFFFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0, 16'h0, 1'b1);
            check_eq("wrap_addr", 32'(rom_addr_o), 32'(wrap_exp[i]));
        end
        repeat (8) cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // Back-to-back flushes with pops in the flush cycles
        repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b0);
        cycle(1'b1, 16'h2000, 16'h0100, 1'b1);
        cycle(1'b1, 16'h3000, 16'h0200, 1'b1);
        cycle(1'b0, 16'h0, 16'h0, 1'b1);
        check_eq("flush2_addr", 32'(rom_addr_o), 32'h30200);
        repeat (10) cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // Asynchronous reset mid-stream
        repeat (5) cycle(1'b0, 16'h0, 16'h0, 1'b1);
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_rom_en", 32'(rom_en_o), 32'd0);
        check_eq("arst_rom_addr", 32'(rom_addr_o), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("arst_level", 32'(level_o), 32'd0);
        check_eq("arst_out_byte", 32'(out_byte_o), 32'd0);
        check_eq("arst_out_ip", 32'(out_ip_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) cycle(1'b0, 16'h0, 16'h0, 1'b1);

        // Random traffic: flushes, wrap-prone targets, varying back-pressure
        for (int i = 0; i < 3000; i++) begin
            mode = (i / 300) % 3;
            rfl  = ($urandom_range(0, 31) == 0);
            case (mode)
                0:       rrdy = 1'b1;
                1:       rrdy = ($urandom_range(0, 1) == 0);
                default: rrdy = ($urandom_range(0, 7) == 0);
            endcase
            rip = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                              : 16'($urandom);
            cycle(rfl, 16'($urandom), rip, rrdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
